// File: rtl/hook_pkg.sv
// Shared types and constants for the Gold Miner hook rope controller:
// state encoding, angle range and the Q.8 trigonometry tables.
package hook_pkg;

  typedef enum logic [1:0] {
    SWING   = 2'd0,
    EXTEND  = 2'd1,
    RETRACT = 2'd2
  } hook_state_t;

  localparam int ANGLE_MAX = 32;
  localparam int ANGLE_MID = 16;
  localparam int TRIG_FRAC = 8;

  // sin((i-16) * 4.6875 deg) * 256, rounded, for i = 0..32
  localparam logic signed [9:0] SIN_TAB [0:32] = '{
    -10'sd247, -10'sd241, -10'sd233, -10'sd224, -10'sd213, -10'sd201,
    -10'sd187, -10'sd172, -10'sd156, -10'sd139, -10'sd121, -10'sd102,
    -10'sd82,  -10'sd62,  -10'sd42,  -10'sd21,   10'sd0,    10'sd21,
     10'sd42,   10'sd62,   10'sd82,   10'sd102,  10'sd121,  10'sd139,
     10'sd156,  10'sd172,  10'sd187,  10'sd201,  10'sd213,  10'sd224,
     10'sd233,  10'sd241,  10'sd247
  };

  // sin(90 deg - m * 4.6875 deg) * 256, rounded; m is the distance from straight down
  localparam logic signed [9:0] COS_TAB [0:16] = '{
    10'sd256, 10'sd255, 10'sd253, 10'sd248, 10'sd242, 10'sd235,
    10'sd226, 10'sd215, 10'sd203, 10'sd190, 10'sd175, 10'sd159,
    10'sd142, 10'sd124, 10'sd106, 10'sd86,  10'sd66
  };

endpackage

// File: rtl/hook_trig_lut.sv
// Registered sine/cosine lookup for the hook swing angle (Q.8, 256 = 1.0).
// Cosine is even, so it is read at the index mirrored about straight down.
module hook_trig_lut
  import hook_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        angleIdx,
  output logic signed [9:0] sinQ,
  output logic signed [9:0] cosQ
);

  logic [5:0] idx_c;
  logic [4:0] mirror;

  always_comb begin
    idx_c  = (angleIdx > 6'(ANGLE_MAX)) ? 6'(ANGLE_MAX) : angleIdx;
    mirror = (idx_c >= 6'(ANGLE_MID)) ? 5'(idx_c - 6'(ANGLE_MID))
                                      : 5'(6'(ANGLE_MID) - idx_c);
  end

  // Reset to the straight-down values so the endpoint pipeline never sees stale data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sinQ <= 10'sd0;
      cosQ <= 10'sd256;
    end else begin
      sinQ <= SIN_TAB[idx_c];
      cosQ <= COS_TAB[mirror];
    end
  end

endmodule

// File: rtl/hook_rope_controller.sv
// Frame-paced hook controller: swings, extends and retracts the rope and
// registers its endpoints. Optional macro HOOK_WEIGHT_SLOWDOWN_EN slows loaded retracts.
module hook_rope_controller
  import hook_pkg::*;
#(
  parameter int         PIVOT_X       = 320,
  parameter int         PIVOT_Y       = 40,
  parameter int         MIN_LEN       = 20,
  parameter int         MAX_LEN       = 400,
  parameter int         EXT_SPEED     = 4,
  parameter int         RETRACT_SPEED = 8,
  parameter int         SCREEN_W      = 640,
  parameter int         SCREEN_H      = 480,
  parameter int         ROPE_WIDTH    = 2,
  parameter logic [7:0] ROPE_COLOR    = 8'h49
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic        grab,
  input  logic [1:0]  grabWeight,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic [10:0] x2,
  output logic [10:0] y2,
  output logic [4:0]  width,
  output logic [7:0]  lineColor,
  output logic [1:0]  hookState,
  output logic        collectPulse,
  output logic [1:0]  collectWeight
);

  localparam logic [9:0]         MIN_L = 10'(MIN_LEN);
  localparam logic [9:0]         MAX_L = 10'(MAX_LEN);
  localparam logic [10:0]        EXT_S = 11'(EXT_SPEED);
  localparam logic [9:0]         RET_S = 10'(RETRACT_SPEED);
  localparam logic signed [12:0] SCR_W = 13'(SCREEN_W);
  localparam logic [10:0]        SCR_H = 11'(SCREEN_H);
  localparam logic signed [12:0] PIV_X = 13'(PIVOT_X);
  localparam logic [10:0]        PIV_Y = 11'(PIVOT_Y);
  localparam logic signed [12:0] X_MAX = 13'sd2047;

  hook_state_t state_q, state_d;
  logic [5:0]  idx_q, idx_d, idx_step;
  logic        dir_q, dir_d;      // 1: index moving toward 0
  logic [9:0]  len_q, len_d;
  logic        loaded_q, loaded_d;
  logic [1:0]  weight_q, weight_d;
  logic        pend_q, pend_d;
  logic        pulse_q, pulse_d;
  logic [1:0]  cw_q, cw_d;

  logic signed [9:0]  sin_q, cos_q;
  logic signed [20:0] prod_x, prod_y;
  logic signed [12:0] x_raw_d, x_raw_q;
  logic [10:0]        x2_d, x2_q, y2_d, y2_q;
  logic [10:0]        len_ext;
  logic [9:0]         rspeed;
  logic               off_screen;

  hook_trig_lut u_lut (
    .clk      (clk),
    .reset    (reset),
    .angleIdx (idx_q),
    .sinQ     (sin_q),
    .cosQ     (cos_q)
  );

`ifdef HOOK_WEIGHT_SLOWDOWN_EN
  logic [9:0] rs_shift;
  always_comb begin
    rs_shift = RET_S >> weight_q;
    rspeed   = RET_S;
    if (loaded_q) rspeed = (rs_shift == 10'd0) ? 10'd1 : rs_shift;
  end
`else
  always_comb rspeed = RET_S;
`endif

  // Off-screen test uses the unclamped tip currently on the outputs
  always_comb begin
    off_screen = x_raw_q[12] || (x_raw_q >= SCR_W) || (y2_q >= SCR_H);
    len_ext    = {1'b0, len_q} + EXT_S;
    idx_step   = dir_q ? (idx_q - 6'd1) : (idx_q + 6'd1);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    len_d    = len_q;
    loaded_d = loaded_q;
    weight_d = weight_q;
    pend_d   = pend_q;
    pulse_d  = 1'b0;
    cw_d     = cw_q;
    case (state_q)
      SWING: begin
        if (startOfFrame && (pend_q || fire)) begin
          state_d = EXTEND;
          pend_d  = 1'b0;
        end else if (startOfFrame) begin
          idx_d = idx_step;
          if (idx_step == 6'(ANGLE_MAX)) dir_d = 1'b1;
          else if (idx_step == 6'd0)     dir_d = 1'b0;
        end else if (fire) begin
          pend_d = 1'b1;
        end
      end
      EXTEND: begin
        if (startOfFrame) begin
          len_d = (len_ext >= {1'b0, MAX_L}) ? MAX_L : len_ext[9:0];
          if (grab) begin
            state_d  = RETRACT;
            loaded_d = 1'b1;
            weight_d = grabWeight;
          end else if (len_d == MAX_L || off_screen) begin
            state_d = RETRACT;
          end
        end
      end
      RETRACT: begin
        if (startOfFrame) begin
          if ({1'b0, len_q} <= ({1'b0, MIN_L} + {1'b0, rspeed})) begin
            len_d   = MIN_L;
            state_d = SWING;
            if (loaded_q) begin
              pulse_d  = 1'b1;
              cw_d     = weight_q;
              loaded_d = 1'b0;
            end
          end else begin
            len_d = len_q - rspeed;
          end
        end
      end
      default: state_d = SWING;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SWING;
      idx_q    <= 6'(ANGLE_MID);
      dir_q    <= 1'b0;
      len_q    <= MIN_L;
      loaded_q <= 1'b0;
      weight_q <= 2'd0;
      pend_q   <= 1'b0;
      pulse_q  <= 1'b0;
      cw_q     <= 2'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      len_q    <= len_d;
      loaded_q <= loaded_d;
      weight_q <= weight_d;
      pend_q   <= pend_d;
      pulse_q  <= pulse_d;
      cw_q     <= cw_d;
    end
  end

  // Endpoint stage: registered LUT output times current length, floor-shifted
  always_comb begin
    prod_x  = $signed({1'b0, len_q}) * sin_q;
    prod_y  = $signed({1'b0, len_q}) * cos_q;
    x_raw_d = PIV_X + 13'(prod_x >>> TRIG_FRAC);
    y2_d    = PIV_Y + 11'(prod_y >>> TRIG_FRAC);
    if (x_raw_d[12])          x2_d = 11'd0;
    else if (x_raw_d > X_MAX) x2_d = 11'd2047;
    else                      x2_d = x_raw_d[10:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_raw_q <= PIV_X;
      x2_q    <= 11'(PIVOT_X);
      y2_q    <= PIV_Y + 11'(MIN_LEN);
    end else begin
      x_raw_q <= x_raw_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
    end
  end

  assign x1            = 11'(PIVOT_X);
  assign y1            = PIV_Y;
  assign x2            = x2_q;
  assign y2            = y2_q;
  assign width         = 5'(ROPE_WIDTH);
  assign lineColor     = ROPE_COLOR;
  assign hookState     = state_q;
  assign collectPulse  = pulse_q;
  assign collectWeight = cw_q;

endmodule

// File: doc/hook_rope_controller.md
# hook_rope_controller

Produces the rope endpoints for the Gold Miner hook. It swings the hook about a fixed pivot, extends it when the player fires, and retracts it empty or loaded. The block runs at frame rate, paced by `startOfFrame`. Its registered `x1/y1/x2/y2/width/color` outputs feed the combinational line renderer directly.

## Interface
- `PIVOT_X`, default 320: rope origin X, in pixels.
- `PIVOT_Y`, default 40: rope origin Y, in pixels.
- `MIN_LEN`, default 20: rest length; also the retract stop point.
- `MAX_LEN`, default 400: extension limit. Must be less than 1024.
- `EXT_SPEED`, default 4: length increment per frame while extending.
- `RETRACT_SPEED`, default 8: length decrement per frame while retracting unloaded.
- `SCREEN_W`, default 640; `SCREEN_H`, default 480: visible bounds.
- `ROPE_WIDTH`, default 2; `ROPE_COLOR`, default 8'h49: constant rope style.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `startOfFrame` in 1: one-cycle tick, once per frame.
- `fire` in 1: one-cycle pulse requesting extension.
- `grab` in 1: hook tip touched an object.
- `grabWeight` in 2: weight of the touched object, 0..3.
- `x1`, `y1` out 11: constant `PIVOT_X` / `PIVOT_Y`.
- `x2`, `y2` out 11: hook tip.
- `width` out 5: `ROPE_WIDTH`.
- `lineColor` out 8: `ROPE_COLOR`.
- `hookState` out 2: current state; encoding is in `hook_pkg`.
- `collectPulse` out 1: one cycle, emitted when a loaded hook arrives home.
- `collectWeight` out 2: weight that was carried; valid with `collectPulse`.

## Operation
- **Registers.**
  - `angleIdx`: 6 bits, range 0..32.
  - `dir`: +1 or −1.
  - `len`: 10 bits, unsigned.
  - `loaded`, `weight`, `firePending`.
- **Angle mapping.** Index 0..32 maps linearly to −75°..+75° in steps of 4.6875°. Index 16 is straight down.
- **State machine.** All state changes happen only on cycles where `startOfFrame`=1.
- **SWING.**
  - Each tick: `angleIdx += dir`.
  - At 32, `dir` becomes −1 and the next tick yields 31. At 0, `dir` becomes +1.
  - A `fire` pulse sets `firePending`. `fire` is ignored in every other state.
  - On a tick with `firePending` set (or `fire`=1 in that same cycle): go to EXTEND, freeze `angleIdx`, clear `firePending`.
- **EXTEND.**
  - Each tick: `len += EXT_SPEED`, saturating at `MAX_LEN`.
  - Exit to RETRACT, checked in this priority order:
    - `grab`=1 in the tick cycle: set `loaded=1` and latch `weight=grabWeight`.
    - `len` has reached `MAX_LEN`.
    - The current tip is off-screen: `x2` < 0 before clamping, `x2` ≥ `SCREEN_W`, or `y2` ≥ `SCREEN_H`. This exit leaves `loaded=0`.
  - `grab` outside the EXTEND tick cycle is ignored.
- **RETRACT.**
  - Each tick: `len -= rspeed`, floored at `MIN_LEN`.
  - When `len` reaches `MIN_LEN`:
    - Go to SWING; `angleIdx` and `dir` are preserved.
    - If `loaded`: emit `collectPulse` for one cycle with `collectWeight=weight`, then clear `loaded`.
- **Endpoint arithmetic.**
  - `hook_trig_lut` returns `sinQ` and `cosQ`: signed 10-bit values in Q.8 (256 = 1.0).
  - `prodX = len * sinQ` and `prodY = len * cosQ`: 21-bit signed.
  - Shift with an arithmetic `>>> 8` (floor).
  - `x2 = PIVOT_X + prodX>>>8`, clamped to 0..2047; negative results clamp to 0.
  - `y2 = PIVOT_Y + prodY>>>8`.
  - The unclamped X value is kept internally for the off-screen check.
- **Reset.** Asynchronous and takes effect at any time, including mid-extend. It yields:
  - state SWING, `angleIdx`=16, `dir`=+1, `len`=`MIN_LEN`;
  - `loaded`=0, `firePending`=0;
  - `collectPulse`=0, `collectWeight`=0;
  - `x2`=`PIVOT_X`, `y2`=`PIVOT_Y`+`MIN_LEN`.

## Timing
- Tick cycle T: state, `angleIdx` and `len` update at the edge ending T.
- T+1: LUT output is registered.
- T+2: `x2` and `y2` are registered with the new values. This is well inside vertical blanking.
- `hookState` changes at the edge ending T.
- `collectPulse` is high in cycle T+1 only.
- The `x1`, `y1`, `width` and `lineColor` outputs are constant.

## Configuration
- The only configuration macro is `HOOK_WEIGHT_SLOWDOWN_EN`.
  - **Defined:** when loaded, `rspeed = max(1, RETRACT_SPEED >> weight)`.
  - **Undefined:** `rspeed = RETRACT_SPEED` always. `weight` is still latched and reported on `collectWeight`.

## Structure
- `hook_pkg` holds:
  - the `hook_state_t` enum: SWING=0, EXTEND=1, RETRACT=2;
  - `ANGLE_MAX`=32;
  - `TRIG_FRAC`=8;
  - the 33-entry sine constant array.
- Sub-module `hook_trig_lut`:
  - input: `angleIdx`; outputs: registered `sinQ` and `cosQ`;
  - cosine is the sine entry at the mirrored index, offset by 90°.

## Test plan
- **Reset.** Assert reset, then release → `x2`=320, `y2`=60, `hookState`=SWING, `collectPulse`=0.
- **Swing.** From reset, 16 ticks → `angleIdx`=32. The 17th tick → 31. `x2` is less than 320 at index 0 and greater than 320 at index 32.
- **Unloaded extend and retract.**
  - Fire at idx 16 → after 95 ticks `len`=400, `y2`=440, then RETRACT.
  - After 48 ticks `len`=20 (clamped), back in SWING, no `collectPulse`.
- **Loaded retract.**
  - `grab` with weight 2 at `len`=100 → RETRACT.
  - Macro on: 40 ticks at 2 per tick to reach 20, then `collectPulse` with `collectWeight`=2.
  - Macro off: 10 ticks.
- **Simultaneous events.**
  - `fire` in the same cycle as a tick → EXTEND on that tick.
  - `grab` in the same tick as `len` reaching `MAX_LEN` → `loaded`=1.
- **Reset mid-extend.** At `len`=200 → immediate SWING, `len`=20, `x2`=320, `y2`=60.
